// File: rtl/ahb_rr_arbiter_pkg.sv
// Shared definitions for the three-master AHB round-robin arbiter:
// HTRANS encodings, arbiter FSM states, master count and small helpers.
package ahb_rr_arbiter_pkg;

  localparam int NM      = 3;
  localparam int CNT_W   = 4;

  typedef logic [1:0]       mst_idx_t;
  typedef logic [CNT_W-1:0] tenure_t;

  localparam tenure_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_PARK   = 2'b00,
    ST_OWN    = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_e;

  function automatic logic [NM-1:0] idx_to_onehot(input mst_idx_t idx);
    logic [NM-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// Round-robin priority selector: returns the first requester after the last
// owner in cyclic order 0->1->2->0; the last owner itself is checked last.
module rr_pick
  import ahb_rr_arbiter_pkg::*;
(
  input  logic [NM-1:0] req,
  input  mst_idx_t      last,
  output mst_idx_t      win
);

  mst_idx_t cand;
  logic     found;

  // NOTE: every variable written here gets a default first, so no path
  // through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    win   = last;
    found = 1'b0;
    cand  = last;
    for (int i = 1; i <= NM; i++) begin
      cand = mst_idx_t'((int'(last) + i) % NM);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter for three masters: round-robin grant with a tenure limit,
// locked-transfer support and address/data-phase muxing toward the bridge.
module ahb_rr_arbiter #(
  parameter int TENURE = 8,
  parameter int NM     = ahb_rr_arbiter_pkg::NM
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NM-1:0]      HBUSREQ,
  input  logic [NM-1:0]      HLOCK,
  input  logic [2*NM-1:0]    HTRANSm,
  input  logic [32*NM-1:0]   HADDRm,
  input  logic [32*NM-1:0]   HWDATAm,
  input  logic [NM-1:0]      HWRITEm,
  input  logic               HREADY,
  output logic [NM-1:0]      HGRANT,
  output logic [1:0]         HMASTER,
  output logic               HMASTLOCK,
  output logic [1:0]         HTRANS,
  output logic [31:0]        HADDR,
  output logic               HWRITE,
  output logic [31:0]        HWDATA
);

  import ahb_rr_arbiter_pkg::*;

  localparam tenure_t TENURE_L = tenure_t'(TENURE);

  arb_state_e state_q, state_d;
  mst_idx_t   owner_q, owner_d;
  mst_idx_t   owner_dp_q, owner_dp_d;
  tenure_t    tenure_q, tenure_d;

  logic [1:0]  trans_a [NM];
  logic [31:0] addr_a  [NM];
  logic [31:0] wdata_a [NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      trans_a[i] = HTRANSm[2*i +: 2];
      addr_a[i]  = HADDRm[32*i +: 32];
      wdata_a[i] = HWDATAm[32*i +: 32];
    end
  end

  logic [1:0]    own_trans;
  logic [NM-1:0] others_req;
  mst_idx_t      pick_win;
  tenure_t       tenure_inc;
  tenure_t       tenure_step;

  assign own_trans  = trans_a[owner_q];
  assign others_req = HBUSREQ & ~idx_to_onehot(owner_q);

  rr_pick u_rr_pick (
    .req  (HBUSREQ),
    .last (owner_q),
    .win  (pick_win)
  );

  // Count the beat accepted on this edge, so the handover happens on the
  // edge that accepts the TENURE-th transfer rather than one beat later.
  assign tenure_inc  = (tenure_q == CNT_MAX) ? tenure_q : tenure_q + tenure_t'(1);
  assign tenure_step = own_trans[1] ? tenure_inc : tenure_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_dp_d = owner_dp_q;
    tenure_d   = tenure_q;

    if (HREADY) begin
      owner_dp_d = owner_q;
      unique case (state_q)
        ST_PARK: begin
          owner_d  = (|HBUSREQ) ? pick_win : mst_idx_t'(0);
          tenure_d = '0;
          if (|HBUSREQ) begin
            state_d = HLOCK[pick_win] ? ST_LOCKED : ST_OWN;
          end
        end

        ST_OWN: begin
          if (!(|HBUSREQ)) begin
            state_d  = ST_PARK;
            owner_d  = '0;
            tenure_d = '0;
          end else if ((|others_req) &&
                       (!HBUSREQ[owner_q] || tenure_step >= TENURE_L)) begin
            owner_d  = pick_win;
            tenure_d = '0;
            state_d  = HLOCK[pick_win] ? ST_LOCKED : ST_OWN;
          end else begin
            tenure_d = tenure_step;
            state_d  = HLOCK[owner_q] ? ST_LOCKED : ST_OWN;
          end
        end

        ST_LOCKED: begin
          // The lock is held through the last SEQ beat of the locked burst.
          tenure_d = tenure_step;
          if (!HLOCK[owner_q] && (own_trans != HTRANS_SEQ)) begin
            state_d = ST_OWN;
          end
        end

        default: begin
          state_d  = ST_PARK;
          owner_d  = '0;
          tenure_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements are written.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_PARK;
      owner_q    <= '0;
      owner_dp_q <= '0;
      tenure_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_dp_q <= owner_dp_d;
      tenure_q   <= tenure_d;
    end
  end

  assign HGRANT    = idx_to_onehot(owner_q);
  assign HMASTER   = owner_q;
  assign HMASTLOCK = (state_q == ST_LOCKED);
  assign HTRANS    = own_trans;
  assign HADDR     = addr_a[owner_q];
  assign HWRITE    = HWRITEm[owner_q];
  assign HWDATA    = wdata_a[owner_dp_q];

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed self-checking bench for ahb_rr_arbiter: reset, handover, tenure,
// lock, wait states and asynchronous reset in the middle of a burst.
module tb_ahb_rr_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [31:0] ADDR0 = 32'h0000_0100;
  localparam logic [31:0] ADDR1 = 32'h1000_0200;
  localparam logic [31:0] ADDR2 = 32'h2000_0300;
  localparam logic [31:0] DATA0 = 32'hAAAA_0000;
  localparam logic [31:0] DATA1 = 32'hBBBB_1111;
  localparam logic [31:0] DATA2 = 32'hCCCC_2222;

  logic        HCLK;
  logic        HRESETn;
  logic [2:0]  HBUSREQ;
  logic [2:0]  HLOCK;
  logic [5:0]  HTRANSm;
  logic [95:0] HADDRm;
  logic [95:0] HWDATAm;
  logic [2:0]  HWRITEm;
  logic        HREADY;
  logic [2:0]  HGRANT;
  logic [1:0]  HMASTER;
  logic        HMASTLOCK;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_rr_arbiter #(.TENURE(8), .NM(3)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANSm   (HTRANSm),
    .HADDRm    (HADDRm),
    .HWDATAm   (HWDATAm),
    .HWRITEm   (HWRITEm),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK),
    .HTRANS    (HTRANS),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_trans(input int m, input logic [1:0] t);
    HTRANSm[2*m +: 2] = t;
  endtask

  initial begin
    HRESETn = 1'b0;
    HBUSREQ = 3'b000;
    HLOCK   = 3'b000;
    HREADY  = 1'b1;
    HWRITEm = 3'b010;
    HADDRm  = {ADDR2, ADDR1, ADDR0};
    HWDATAm = {DATA2, DATA1, DATA0};
    HTRANSm = {T_NONSEQ, T_NONSEQ, T_BUSY};

    // Reset values, HTRANS/HADDR follow master 0
    #3;
    check("rst_hgrant",    HGRANT,    3'b001);
    check("rst_hmaster",   HMASTER,   2'd0);
    check("rst_hmastlock", HMASTLOCK, 1'b0);
    check("rst_htrans",    HTRANS,    T_BUSY);
    check("rst_haddr",     HADDR,     ADDR0);
    check("rst_hwdata",    HWDATA,    DATA0);

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    set_trans(0, T_IDLE);
    tick();
    check("park_hgrant", HGRANT, 3'b001);

    // Handover from parked master 0 to master 1
    HBUSREQ = 3'b110;
    tick();
    check("ho_hgrant",  HGRANT,  3'b010);
    check("ho_hmaster", HMASTER, 2'd1);
    check("ho_haddr",   HADDR,   ADDR1);
    check("ho_hwrite",  HWRITE,  1'b1);
    check("ho_hwdata0", HWDATA,  DATA0);
    tick();
    check("ho_hwdata1", HWDATA,  DATA1);
    check("ho_hold1",   HGRANT,  3'b010);

    // Tenure: beats 2..3, five wait states, beats 4..7 keep master 1
    set_trans(1, T_SEQ);
    repeat (2) tick();
    HREADY = 1'b0;
    repeat (5) tick();
    check("ten_ws_hgrant", HGRANT, 3'b010);
    HREADY = 1'b1;
    repeat (4) tick();
    check("ten_beat7_hgrant", HGRANT, 3'b010);
    tick();
    check("ten_beat8_hgrant",  HGRANT,  3'b100);
    check("ten_beat8_hmaster", HMASTER, 2'd2);

    // Master 2 tenure: 8 NONSEQ beats, then back to master 1
    repeat (7) tick();
    check("ten2_beat7_hgrant", HGRANT, 3'b100);
    tick();
    check("ten2_beat8_hgrant",  HGRANT,  3'b010);
    check("ten2_beat8_hmaster", HMASTER, 2'd1);

    // Pending handover stalled by wait states
    HBUSREQ = 3'b100;
    set_trans(1, T_IDLE);
    HREADY  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ws_hgrant_%0d", i),  HGRANT,  3'b010);
      check($sformatf("ws_hmaster_%0d", i), HMASTER, 2'd1);
    end
    HREADY = 1'b1;
    tick();
    check("ws_done_hgrant",  HGRANT,  3'b100);
    check("ws_done_hmaster", HMASTER, 2'd2);

    // Locked ownership by master 2 against competing requests
    HLOCK   = 3'b100;
    HBUSREQ = 3'b111;
    set_trans(2, T_NONSEQ);
    tick();
    check("lk_enter_hmastlock", HMASTLOCK, 1'b1);
    check("lk_enter_hgrant",    HGRANT,    3'b100);
    set_trans(2, T_SEQ);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("lk_hgrant_%0d", i),    HGRANT,    3'b100);
      check($sformatf("lk_hmastlock_%0d", i), HMASTLOCK, 1'b1);
    end
    HLOCK = 3'b000;
    tick();
    check("lk_seq_hmastlock", HMASTLOCK, 1'b1);
    check("lk_seq_hgrant",    HGRANT,    3'b100);
    set_trans(2, T_IDLE);
    HBUSREQ = 3'b011;
    tick();
    check("lk_exit_hmastlock", HMASTLOCK, 1'b0);
    check("lk_exit_hgrant",    HGRANT,    3'b100);
    tick();
    check("lk_next_hgrant",  HGRANT,  3'b001);
    check("lk_next_hmaster", HMASTER, 2'd0);

    // Reset asserted during master 1's third SEQ-burst beat
    HBUSREQ = 3'b010;
    HLOCK   = 3'b010;
    set_trans(0, T_BUSY);
    set_trans(1, T_NONSEQ);
    tick();
    check("mb_hgrant",    HGRANT,    3'b010);
    check("mb_hmastlock", HMASTLOCK, 1'b1);
    tick();
    set_trans(1, T_SEQ);
    tick();
    check("mb_pre_htrans", HTRANS, T_SEQ);
    check("mb_pre_hwdata", HWDATA, DATA1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("mb_rst_hgrant",    HGRANT,    3'b001);
    check("mb_rst_hmaster",   HMASTER,   2'd0);
    check("mb_rst_hmastlock", HMASTLOCK, 1'b0);
    check("mb_rst_htrans",    HTRANS,    T_BUSY);
    check("mb_rst_hwdata",    HWDATA,    DATA0);

    // Simultaneous requests after reset; non-owner HLOCK is ignored
    @(negedge HCLK);
    HRESETn = 1'b1;
    HLOCK   = 3'b100;
    HBUSREQ = 3'b111;
    tick();
    check("sim_hgrant",    HGRANT,    3'b010);
    check("sim_hmastlock", HMASTLOCK, 1'b0);
    HBUSREQ = 3'b101;
    set_trans(1, T_IDLE);
    tick();
    check("sim2_hgrant",    HGRANT,    3'b100);
    check("sim2_hmastlock", HMASTLOCK, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
